// File: rtl/macc_pkg.sv
// rtl/macc_pkg.sv - shared constants and arithmetic helpers for the MAC pipeline
package macc_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_FRAC  = 0;
  localparam int DEF_GUARD = 8;

  // Widest accumulator the narrowing helpers can handle.
  localparam int MAX_ACC_W = 128;

  function automatic int acc_width(input int width, input int guard);
    return 2 * width + guard;
  endfunction

  // True when v does not fit in a signed field of the given width.
  function automatic logic narrow_ovf(input logic signed [MAX_ACC_W-1:0] v,
                                      input int width);
    logic signed [MAX_ACC_W-1:0] top;
    top = v >>> (width - 1);
    return !((top == '0) || (top == '1));
  endfunction

  // Clamp v to [-2^(width-1), 2^(width-1)-1]; the caller keeps the low width bits.
  function automatic logic signed [MAX_ACC_W-1:0] narrow_sat(input logic signed [MAX_ACC_W-1:0] v,
                                                             input int width);
    logic signed [MAX_ACC_W-1:0] lim;
    lim = '1;
    lim = lim <<< (width - 1);
    if (!narrow_ovf(v, width)) begin
      return v;
    end else if (v[MAX_ACC_W-1]) begin
      return lim;
    end else begin
      return ~lim;
    end
  endfunction

endpackage

// File: rtl/macc_if.sv
// rtl/macc_if.sv - operand/result stream bundle between a producer and macc_pipe
interface macc_if
  import macc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic signed [WIDTH-1:0] in0;
  logic signed [WIDTH-1:0] in1;
  logic signed [WIDTH-1:0] in_acc;
  logic                    in_first;
  logic                    in_last;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] out;
  logic                    out_ovf;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in0, in1, in_acc, in_first, in_last, in_valid, out_ready,
    input  in_ready, out, out_ovf, out_valid
  );

  modport slave (
    input  in0, in1, in_acc, in_first, in_last, in_valid, out_ready,
    output in_ready, out, out_ovf, out_valid
  );

endinterface

// File: rtl/macc_sat.sv
// rtl/macc_sat.sv - fixed-point rescale (floor) and saturating narrow of the accumulator
module macc_sat
  import macc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC,
  parameter int ACC_W = acc_width(DEF_WIDTH, DEF_GUARD)
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [WIDTH-1:0] res,
  output logic                    ovf
);

  logic signed [ACC_W-1:0]     shifted;
  logic signed [MAX_ACC_W-1:0] wide;

  assign shifted = acc >>> FRAC;
  assign wide    = MAX_ACC_W'(shifted);
  assign ovf     = narrow_ovf(wide, WIDTH);
  assign res     = WIDTH'(narrow_sat(wide, WIDTH));

endmodule

// File: rtl/macc_pipe.sv
// rtl/macc_pipe.sv - two-stage streaming multiply-accumulate with bias, scaling and saturation
module macc_pipe
  import macc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC,
  parameter int GUARD = DEF_GUARD
) (
  input  logic clk,
  input  logic reset,
  macc_if.slave bus
);

  localparam int ACC_W = acc_width(WIDTH, GUARD);
  localparam int P_W   = 2 * WIDTH;

  logic                    stall;
  logic                    accept;
  logic signed [P_W-1:0]   prod;

  logic                    s1_valid;
  logic                    s1_first;
  logic                    s1_last;
  logic signed [P_W-1:0]   s1_p;
  logic signed [WIDTH-1:0] s1_bias;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] acc_next;

  logic signed [WIDTH-1:0] sat_res;
  logic                    sat_ovf;

  logic signed [WIDTH-1:0] out_q;
  logic                    ovf_q;
  logic                    valid_q;

  // Both stages freeze together while a result waits downstream.
  assign stall        = valid_q && !bus.out_ready;
  assign accept       = bus.in_valid && !stall;
  assign bus.in_ready = !stall;

  assign bus.out       = out_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.out_valid = valid_q;

  assign prod = P_W'(bus.in0) * P_W'(bus.in1);

  // A first beat restarts from the scaled bias, dropping any partial sum.
  assign acc_base = s1_first ? (ACC_W'(s1_bias) <<< FRAC) : acc;
  assign acc_next = acc_base + ACC_W'(s1_p);

  macc_sat #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_sat (
    .acc (acc_next),
    .res (sat_res),
    .ovf (sat_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_p     <= '0;
      s1_bias  <= '0;
      acc      <= '0;
      out_q    <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) begin
        s1_p     <= prod;
        s1_first <= bus.in_first;
        s1_last  <= bus.in_last;
        s1_bias  <= bus.in_acc;
      end
      valid_q <= s1_valid && s1_last;
      if (s1_valid) begin
        if (s1_last) begin
          out_q <= sat_res;
          ovf_q <= sat_ovf;
          acc   <= '0;
        end else begin
          acc <= acc_next;
        end
      end
    end
  end

endmodule
